// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and op width shared by alu_seq and alu_mul_iter
package alu_pkg;
  localparam int ALU_OP_W = 4;
  typedef enum logic [ALU_OP_W-1:0] {
    ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4, SLT = 4'd5,
    SLTU = 4'd6, SLL = 4'd7, SRL = 4'd8, SRA = 4'd9, PASSB = 4'd10, MUL = 4'd11
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, BUSY, VALID} alu_state_e;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier (ports clk/reset/start/a/b -> busy/done/product), low WIDTH bits after WIDTH cycles
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CW-1:0] cnt;
  assign done = busy & (cnt == '0);
  assign product = acc;
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= CW'(WIDTH);
      acc <= '0;
      mcand <= a;
      mplier <= b;
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy) begin
      acc <= acc + (mplier[0] ? mcand : '0);
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered valid/ready ALU (in: op/src_a/src_b/in_tag, out: result/zero/illegal/out_tag), iterative MUL under ALU_SEQ_MUL_EN
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    src_a,
  input  logic [WIDTH-1:0]    src_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic                zero,
  output logic                illegal,
  output logic [TAG_W-1:0]    out_tag
);
  localparam int SH_W = $clog2(WIDTH);
  alu_state_e state, state_n;
  logic xfer_in, is_mul, mul_busy, mul_done, ill;
  logic [WIDTH-1:0] res, mul_p;
  logic [SH_W-1:0] sh;
`ifdef ALU_SEQ_MUL_EN
  assign is_mul = op == MUL;
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .reset(reset), .start(xfer_in & is_mul), .a(src_a), .b(src_b),
    .busy(mul_busy), .done(mul_done), .product(mul_p)
  );
`else
  assign is_mul = 1'b0;
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_p = '0;
`endif
  assign sh = src_b[SH_W-1:0];
  assign out_valid = state == VALID;
  assign in_ready = (state == IDLE & !mul_busy) | (state == VALID & out_ready);
  assign xfer_in = in_valid & in_ready;
  always_comb begin
    res = '0;
    ill = 1'b0;
    case (op)
      ADD:     res = src_a + src_b;
      SUB:     res = src_a - src_b;
      AND:     res = src_a & src_b;
      OR:      res = src_a | src_b;
      XOR:     res = src_a ^ src_b;
      SLT:     res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      SLTU:    res = {{(WIDTH-1){1'b0}}, src_a < src_b};
      SLL:     res = src_a << sh;
      SRL:     res = src_a >> sh;
      SRA:     res = $signed(src_a) >>> sh;
      PASSB:   res = src_b;
      default: ill = 1'b1;
    endcase
  end
  always_comb begin
    state_n = xfer_in ? (is_mul ? BUSY : VALID)
            : state == BUSY ? (mul_done ? VALID : BUSY)
            : (state == VALID & !out_ready) ? VALID : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      result <= '0;
      zero <= 1'b1;
      illegal <= 1'b0;
      out_tag <= '0;
    end else begin
      state <= state_n;
      if (xfer_in) out_tag <= in_tag;
      if (xfer_in & !is_mul) begin
        result <= res;
        zero <= res == '0;
        illegal <= ill;
      end else if (state == BUSY & mul_done) begin
        result <= mul_p;
        zero <= mul_p == '0;
        illegal <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector self-checking bench for alu_seq
module tb_alu_seq;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, zero, illegal;
  logic [3:0] op = '0;
  logic [31:0] src_a = '0, src_b = '0, result;
  logic [4:0] in_tag = '0, out_tag;
  int n_checks = 0, n_err = 0;
  alu_seq #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src_a(src_a), .src_b(src_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal), .out_tag(out_tag)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, input logic [31:0] er, input logic ei);
    op = o; src_a = a; src_b = b; in_tag = t; in_valid = 1'b1;
    #1;
    check({nm, ".in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({nm, ".out_valid"}, 64'(out_valid), 64'(1));
    check({nm, ".result"}, 64'(result), 64'(er));
    check({nm, ".zero"}, 64'(zero), 64'(er == 32'h0));
    check({nm, ".illegal"}, 64'(illegal), 64'(ei));
    check({nm, ".tag"}, 64'(out_tag), 64'(t));
  endtask
  initial begin
    int n;
    logic bad;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst.out_valid", 64'(out_valid), 64'(0));
    check("rst.result", 64'(result), 64'(0));
    check("rst.zero", 64'(zero), 64'(1));
    check("rst.illegal", 64'(illegal), 64'(0));
    check("rst.in_ready", 64'(in_ready), 64'(1));
    run_op("add", 4'd0, 32'hFFFF_FFFF, 32'h1, 5'h01, 32'h0, 1'b0);
    run_op("sub", 4'd1, 32'd5, 32'd7, 5'h02, 32'hFFFF_FFFE, 1'b0);
    run_op("slt", 4'd5, 32'h8000_0000, 32'h1, 5'h03, 32'h1, 1'b0);
    run_op("sltu", 4'd6, 32'h8000_0000, 32'h1, 5'h04, 32'h0, 1'b0);
    run_op("sra", 4'd9, 32'h8000_0000, 32'h21, 5'h05, 32'hC000_0000, 1'b0);
    run_op("srl", 4'd8, 32'h8000_0000, 32'h21, 5'h06, 32'h4000_0000, 1'b0);
    run_op("sll", 4'd7, 32'h1, 32'd31, 5'h07, 32'h8000_0000, 1'b0);
    run_op("and", 4'd2, 32'hF0F0_1234, 32'hFF00_00FF, 5'h08, 32'hF000_0034, 1'b0);
    run_op("or", 4'd3, 32'hF0F0_0000, 32'h0F00_0001, 5'h09, 32'hFFF0_0001, 1'b0);
    run_op("xor", 4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 5'h0A, 32'h5555_5555, 1'b0);
    run_op("passb", 4'd10, 32'h1234_5678, 32'hCAFE_BABE, 5'h0B, 32'hCAFE_BABE, 1'b0);
    run_op("ill15", 4'd15, 32'h1234_5678, 32'h1, 5'h1A, 32'h0, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op("bp", 4'd0, 32'd3, 32'd4, 5'h07, 32'd7, 1'b0);
    in_valid = 1'b1; op = 4'd4; src_a = 32'hFF; src_b = 32'h0F; in_tag = 5'h09;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp.hold_valid", 64'(out_valid), 64'(1));
      check("bp.hold_result", 64'(result), 64'(7));
      check("bp.hold_tag", 64'(out_tag), 64'(7));
      check("bp.in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    #1;
    check("b2b.in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b.out_valid", 64'(out_valid), 64'(1));
    check("b2b.result", 64'(result), 64'(32'hF0));
    check("b2b.tag", 64'(out_tag), 64'(9));
    @(posedge clk); #1;
    check("drain.out_valid", 64'(out_valid), 64'(0));
`ifdef ALU_SEQ_MUL_EN
    op = 4'd11; src_a = 32'hFFFF; src_b = 32'h1_0001; in_tag = 5'h03; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0; bad = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (in_ready) bad = 1'b1;
      @(posedge clk); #1;
      if (out_valid) begin n = i; break; end
    end
    check("mul.latency", 64'(n), 64'(33));
    check("mul.busy_in_ready", 64'(bad), 64'(0));
    check("mul.result", 64'(result), 64'(32'hFFFF_FFFF));
    check("mul.illegal", 64'(illegal), 64'(0));
    check("mul.tag", 64'(out_tag), 64'(3));
    @(posedge clk); #1;
    op = 4'd11; src_a = 32'd6; src_b = 32'd7; in_tag = 5'h04; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mulrst.out_valid", 64'(out_valid), 64'(0));
    check("mulrst.in_ready", 64'(in_ready), 64'(1));
    bad = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) bad = 1'b1;
    end
    check("mulrst.no_out", 64'(bad), 64'(0));
    run_op("postrst", 4'd0, 32'd10, 32'd20, 5'h11, 32'd30, 1'b0);
`else
    run_op("mul_ill", 4'd11, 32'hFFFF, 32'h1_0001, 5'h03, 32'h0, 1'b1);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
